// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of the two requester ports and the Data_Memory port
//               around dmem_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wd0;
    logic [DATA_WIDTH-1:0] wd1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  done0;
    logic                  done1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
        output gnt0, gnt1, done0, done1, rdata, busy, mem_we, mem_addr, mem_wd
    );

    // Requester and memory side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
        input  gnt0, gnt1, done0, done1, rdata, busy, mem_we, mem_addr, mem_wd
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port req/gnt/done arbiter in front of the single 256-bit
//               Data_Memory port (round-robin or fixed priority).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int ARB_MODE   = 0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dmem_arbiter_if.slave   bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic c_ROUND_ROBIN = (ARB_MODE == 0);

    logic [1:0]            r_state;
    logic                  r_owner;
    logic                  r_last_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wd;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_done0;
    logic                  r_done1;
    logic                  r_mem_we;
    logic                  r_busy;

    logic w_any_req;
    logic w_pick1;
    logic w_sel_we;

    assign w_any_req = bus.req0 | bus.req1;
    // Port 1 wins when alone, or in round-robin when port 0 owned the last access
    assign w_pick1   = bus.req1 & (~bus.req0 | (c_ROUND_ROBIN & ~r_last_owner));
    assign w_sel_we  = w_pick1 ? bus.we1 : bus.we0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wd         <= '0;
            r_rdata      <= '0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_mem_we     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_pick1;
                        r_last_owner <= w_pick1;
                        r_we         <= w_sel_we;
                        r_addr       <= w_pick1 ? bus.addr1 : bus.addr0;
                        r_wd         <= w_pick1 ? bus.wd1 : bus.wd0;
                        r_gnt0       <= ~w_pick1;
                        r_gnt1       <= w_pick1;
                        r_mem_we     <= w_sel_we;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= bus.mem_rd;
                    end
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_done0  <= ~r_owner;
                    r_done1  <= r_owner;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = r_gnt0;
    assign bus.gnt1     = r_gnt1;
    assign bus.done0    = r_done0;
    assign bus.done1    = r_done1;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_addr;
    assign bus.mem_wd   = r_wd;

endmodule

`default_nettype wire
